// File: rtl/twobit_gt_bist_if.sv
// twobit_gt_bist_if
// Purpose: groups the operand/result bus between the BIST engine and the
//          twobit_gt comparator it exercises.
// Signals:
//   dut_a  WIDTH  operand A, driven by the BIST engine
//   dut_b  WIDTH  operand B, driven by the BIST engine
//   dut_f  1      comparator result (A > B), driven by the comparator
// Modports:
//   master  BIST side: drives the operands, receives the result
//   slave   comparator side: receives the operands, drives the result
interface twobit_gt_bist_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_f;

  modport master (output dut_a, output dut_b, input dut_f);
  modport slave  (input dut_a, input dut_b, output dut_f);
endinterface

// File: rtl/twobit_gt_bist.sv
// twobit_gt_bist
// Purpose: on-chip stimulus/response checker for the twobit_gt comparator
//          (F = A > B). On start it sweeps every {A,B} vector, holds each one
//          for DWELL cycles, samples F on the last held cycle, compares it
//          against the golden unsigned A > B and counts mismatches.
// Parameters:
//   WIDTH  operand width; the vector counter is 2*WIDTH bits
//   DWELL  cycles each vector is held (>= 1)
//   ERR_W  width of err_count; the count saturates at 2^ERR_W-1
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   start           one-cycle pulse, honoured only in IDLE or DONE
//   dut_bus         master side of the comparator bus (dut_a, dut_b out; dut_f in)
//   busy            high while a sweep is running
//   done            high once a sweep has finished, until the next start or reset
//   pass            valid while done: 1 iff no mismatch was seen
//   err_count       saturating mismatch count
//   first_fail_vec  {A,B} of the first mismatching vector
//   first_fail_vld  first_fail_vec holds a valid capture
module twobit_gt_bist #(
  parameter int WIDTH = 2,
  parameter int DWELL = 4,
  parameter int ERR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  twobit_gt_bist_if.master     dut_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail_vec,
  output logic                 first_fail_vld
);

  localparam int VEC_W   = 2 * WIDTH;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [VEC_W-1:0]   VEC_MAX    = {VEC_W{1'b1}};
  localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [VEC_W-1:0]   vec;
  logic [DWELL_W-1:0] dwell;

  logic last_sample;
  logic golden;
  logic mismatch;
  logic sweep_end;

  // The operands are straight slices of the vector register, so they are
  // registered and read 0 whenever vec is 0 (reset and IDLE).
  assign dut_bus.dut_a = vec[VEC_W-1:WIDTH];
  assign dut_bus.dut_b = vec[WIDTH-1:0];

  // The comparison happens on the last held cycle of each vector, giving the
  // comparator DWELL-1 cycles of settling before its output is trusted.
  assign last_sample = (state_q == S_RUN) && (dwell == DWELL_LAST);
  assign golden      = (vec[VEC_W-1:WIDTH] > vec[WIDTH-1:0]);
  assign mismatch    = last_sample && (dut_bus.dut_f != golden);
  assign sweep_end   = last_sample && (vec == VEC_MAX);

  // State register; reset takes priority over any start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only counts from IDLE or DONE, so a pulse in
  // the middle of a sweep cannot restart it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (sweep_end) state_d = S_DONE;
      S_DONE:  if (start)     state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Sweep datapath: vector/dwell counters and result capture. Entering RUN
  // clears the previous results; pass is folded in on the final sample so
  // that a mismatch on the very last vector is still reflected.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec            <= '0;
      dwell          <= '0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if (state_q != S_RUN) begin
      if (start) begin
        vec            <= '0;
        dwell          <= '0;
        pass           <= 1'b0;
        err_count      <= '0;
        first_fail_vec <= '0;
        first_fail_vld <= 1'b0;
      end
    end else if (dwell == DWELL_LAST) begin
      dwell <= '0;
      if (mismatch) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + ERR_W'(1);
        end
        if (!first_fail_vld) begin
          first_fail_vec <= vec;
          first_fail_vld <= 1'b1;
        end
      end
      if (vec == VEC_MAX) begin
        pass <= (err_count == '0) && !mismatch;
      end else begin
        vec <= vec + VEC_W'(1);
      end
    end else begin
      dwell <= dwell + DWELL_W'(1);
    end
  end

endmodule
